// File: rtl/bus_fabric.sv
// 65C02 bus interconnect: registered address decode over up to 8 base/mask slots,
// per-slot wait states via RDY, read-data mux and a small maskable interrupt controller.
module bus_fabric #(
  parameter int                     N_SLOTS   = 4,
  parameter logic [16*N_SLOTS-1:0]  SLOT_BASE = {16'h8000, 16'h6000, 16'h5000, 16'h0000},
  parameter logic [16*N_SLOTS-1:0]  SLOT_MASK = {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000},
  parameter logic [4*N_SLOTS-1:0]   SLOT_WAIT = 16'h0000,
  parameter logic [15:0]            CTRL_BASE = 16'h7000,
  parameter logic [7:0]             FILL_BYTE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            cpu_ad,
  input  logic                   cpu_we,
  input  logic [7:0]             cpu_do,
  output logic [7:0]             cpu_di,
  output logic                   cpu_rdy,
  output logic                   cpu_irq,
  output logic [15:0]            bus_addr,
  output logic                   bus_we,
  output logic [N_SLOTS-1:0]     slot_cs,
  input  logic [8*N_SLOTS-1:0]   slot_do,
  input  logic [N_SLOTS-1:0]     slot_irq_n
);

  localparam logic [7:0] EN_MASK = 8'hFF >> (8 - N_SLOTS);

  logic [15:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [N_SLOTS-1:0] cs_q, cs_d;
  logic               ctrl_q, ctrl_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [7:0]         en_q, en_d;
  logic               err_q, err_d;
  logic [N_SLOTS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic               irq_q, irq_d;

  logic               rdy_s, ctrl_hit_s, slot_hit_s, miss_s, ctrl_wr_s;
  logic [N_SLOTS-1:0] match_s, onehot_s, synced_s, pending_s;
  logic [2:0]         hit_idx_s;
  logic [3:0]         hit_wait_s;
  logic [7:0]         vec_s, slot_rd_s, ctrl_rd_s;

  assign rdy_s      = (wcnt_q == 4'd0);
  assign ctrl_hit_s = ((cpu_ad & 16'hFFFC) == CTRL_BASE);
  assign miss_s     = !ctrl_hit_s && !slot_hit_s;
  assign ctrl_wr_s  = ctrl_q && we_q && rdy_s;
  assign synced_s   = ~sync2_q;
  assign pending_s  = synced_s & en_q[N_SLOTS-1:0];

  // Raw per-slot base/mask comparison of the live CPU address
  always_comb begin
    match_s = {N_SLOTS{1'b0}};
    for (int i = 0; i < N_SLOTS; i++) begin
      match_s[i] = ((cpu_ad & SLOT_MASK[16*i +: 16]) == SLOT_BASE[16*i +: 16]);
    end
  end

  // Lowest-index slot wins; scanning downwards lets lower indices overwrite
  always_comb begin
    slot_hit_s = 1'b0;
    hit_idx_s  = 3'd0;
    hit_wait_s = 4'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      slot_hit_s = slot_hit_s | match_s[i];
      hit_idx_s  = match_s[i] ? 3'(i) : hit_idx_s;
      hit_wait_s = match_s[i] ? SLOT_WAIT[4*i +: 4] : hit_wait_s;
    end
    onehot_s = {N_SLOTS{1'b0}};
    for (int i = 0; i < N_SLOTS; i++) begin
      onehot_s[i] = slot_hit_s && !ctrl_hit_s && (hit_idx_s == 3'(i));
    end
  end

  // Read-side helpers: lowest pending vector and selected slot byte
  always_comb begin
    vec_s = 8'h80;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      vec_s = pending_s[i] ? 8'(i) : vec_s;
    end
    slot_rd_s = 8'h00;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_rd_s = slot_rd_s | (cs_q[i] ? slot_do[8*i +: 8] : 8'h00);
    end
    case (addr_q[1:0])
      2'd0:    ctrl_rd_s = {err_q, 7'(pending_s)};
      2'd1:    ctrl_rd_s = en_q & EN_MASK;
      2'd2:    ctrl_rd_s = vec_s;
      2'd3:    ctrl_rd_s = 8'(synced_s);
      default: ctrl_rd_s = 8'h00;
    endcase
    if (ctrl_q) begin
      cpu_di = ctrl_rd_s;
    end else if (|cs_q) begin
      cpu_di = slot_rd_s;
    end else begin
      cpu_di = FILL_BYTE;
    end
  end

  // Next-state: the address phase loads only when ready, otherwise the wait counts down
  always_comb begin
    if (rdy_s) begin
      addr_d = cpu_ad;
      we_d   = cpu_we;
      cs_d   = onehot_s;
      ctrl_d = ctrl_hit_s;
      wcnt_d = (ctrl_hit_s || !slot_hit_s) ? 4'd0 : hit_wait_s;
    end else begin
      addr_d = addr_q;
      we_d   = we_q;
      cs_d   = cs_q;
      ctrl_d = ctrl_q;
      wcnt_d = wcnt_q - 4'd1;
    end
    if (ctrl_wr_s && (addr_q[1:0] == 2'd1)) begin
      en_d = cpu_do & EN_MASK;
    end else begin
      en_d = en_q;
    end
    // A new miss beats a same-cycle clear
    if (rdy_s && miss_s) begin
      err_d = 1'b1;
    end else if (ctrl_wr_s && (addr_q[1:0] == 2'd0) && cpu_do[7]) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    sync1_d = slot_irq_n;
    sync2_d = sync1_q;
    irq_d   = |pending_s;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      cs_q    <= {N_SLOTS{1'b0}};
      ctrl_q  <= 1'b0;
      wcnt_q  <= 4'd0;
      en_q    <= 8'hFF;
      err_q   <= 1'b0;
      sync1_q <= {N_SLOTS{1'b0}};
      sync2_q <= {N_SLOTS{1'b0}};
      irq_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      cs_q    <= cs_d;
      ctrl_q  <= ctrl_d;
      wcnt_q  <= wcnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      irq_q   <= irq_d;
    end
  end

  assign cpu_rdy  = rdy_s;
  assign cpu_irq  = irq_q;
  assign bus_addr = addr_q;
  assign bus_we   = we_q & rdy_s;
  assign slot_cs  = cs_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed vector table, hand sequences for
// multi-cycle corners, and randomized accesses against a transaction-level model.
module tb_bus_fabric;

  localparam logic [15:0] IDLE = 16'h8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_ad, bus_addr;
  logic        cpu_we, cpu_rdy, cpu_irq, bus_we;
  logic [7:0]  cpu_do, cpu_di;
  logic [3:0]  slot_cs, slot_irq_n;
  logic [31:0] slot_do;

  logic [15:0] b_ad, b_addr;
  logic        b_we, b_rdy, b_irq, b_bwe;
  logic [7:0]  b_do, b_di;
  logic [3:0]  b_cs, b_irq_n;
  logic [31:0] b_sdo;

  always #5 clk = ~clk;

  // slot0 waits 5, slot1 waits 3, default bases
  bus_fabric #(.N_SLOTS(4), .SLOT_WAIT(16'h0035)) u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_ad(cpu_ad), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_irq(cpu_irq), .bus_addr(bus_addr),
    .bus_we(bus_we), .slot_cs(slot_cs), .slot_do(slot_do), .slot_irq_n(slot_irq_n));

  // Overlapping decode: slot0 8000/8000, slot1 F000/F000, slot2 1000/F000, slot3 2000/F000
  bus_fabric #(.N_SLOTS(4),
    .SLOT_BASE({16'h2000, 16'h1000, 16'hF000, 16'h8000}),
    .SLOT_MASK({16'hF000, 16'hF000, 16'hF000, 16'h8000})) u_ovl (
    .clk(clk), .rst_n(rst_n), .cpu_ad(b_ad), .cpu_we(b_we), .cpu_do(b_do),
    .cpu_di(b_di), .cpu_rdy(b_rdy), .cpu_irq(b_irq), .bus_addr(b_addr),
    .bus_we(b_bwe), .slot_cs(b_cs), .slot_do(b_sdo), .slot_irq_n(b_irq_n));

  int checks = 0;
  int failures = 0;

  logic [15:0] base_a [4] = '{16'h0000, 16'h5000, 16'h6000, 16'h8000};
  logic [15:0] mask_a [4] = '{16'hC000, 16'hFFF0, 16'hFFF0, 16'h8000};
  int          wait_a [4] = '{5, 3, 0, 0};

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  cs;
    int          waits;
    logic [7:0]  di;
  } vec_t;
  vec_t tbl [11];

  int          r_waits;
  logic [3:0]  r_cs;
  logic [7:0]  r_di;
  logic        r_we, r_early, r_held, r_irq;

  logic [7:0]  en_m;
  logic        err_m;
  logic [3:0]  irq_n_m, pend_m;
  logic [15:0] a;
  logic        w;
  logic [7:0]  d, exp_di, vec_m;
  logic [3:0]  exp_cs;
  int          k, exp_wait, cat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One CPU access: address edge, wait cycles, data cycle sample, then the commit edge
  task automatic do_access(input logic [15:0] ad, input logic wr, input logic [7:0] dat,
                           output int waits, output logic [3:0] cs, output logic [7:0] di,
                           output logic we_fin, output logic early, output logic held,
                           output logic irq);
    @(negedge clk);
    cpu_ad = ad; cpu_we = wr; cpu_do = dat;
    @(posedge clk); #1;
    cpu_ad = IDLE; cpu_we = 1'b0;
    waits = 0; early = 1'b0; held = 1'b1;
    while (!cpu_rdy && waits < 20) begin
      if (bus_we) early = 1'b1;
      if (bus_addr !== ad) held = 1'b0;
      @(posedge clk); #1;
      waits++;
    end
    if (bus_addr !== ad) held = 1'b0;
    cs = slot_cs; di = cpu_di; we_fin = bus_we; irq = cpu_irq;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [15:0] ad, output logic [7:0] di);
    int wt; logic [3:0] c; logic x, e, h, q;
    do_access(ad, 1'b0, 8'h00, wt, c, di, x, e, h, q);
  endtask

  task automatic wr(input logic [15:0] ad, input logic [7:0] dat);
    int wt; logic [3:0] c; logic [7:0] di; logic x, e, h, q;
    do_access(ad, 1'b1, dat, wt, c, di, x, e, h, q);
  endtask

  function automatic int model_decode(input logic [15:0] ad);
    if ((ad & 16'hFFFC) == 16'h7000) return -2;
    for (int i = 0; i < 4; i++) begin
      if ((ad & mask_a[i]) == base_a[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{16'h6004, 4'b0100, 0, 8'hD2};
    tbl[1]  = '{16'h5001, 4'b0010, 3, 8'hD1};
    tbl[2]  = '{16'h0123, 4'b0001, 5, 8'hD0};
    tbl[3]  = '{16'h8000, 4'b1000, 0, 8'hD3};
    tbl[4]  = '{16'hFFFF, 4'b1000, 0, 8'hD3};
    tbl[5]  = '{16'h4000, 4'b0000, 0, 8'hFF};
    tbl[6]  = '{16'h500F, 4'b0010, 3, 8'hD1};
    tbl[7]  = '{16'h5010, 4'b0000, 0, 8'hFF};
    tbl[8]  = '{16'h3FFF, 4'b0001, 5, 8'hD0};
    tbl[9]  = '{16'h6010, 4'b0000, 0, 8'hFF};
    tbl[10] = '{16'h7004, 4'b0000, 0, 8'hFF};

    rst_n = 1'b0;
    cpu_ad = IDLE; cpu_we = 1'b0; cpu_do = 8'h00;
    slot_do = 32'hD3D2D1D0; slot_irq_n = 4'hF;
    b_ad = IDLE; b_we = 1'b0; b_do = 8'h00; b_sdo = 32'hB3B2B1B0; b_irq_n = 4'hF;
    #12;
    chk("rst_bus_addr", bus_addr, 16'h0000);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_slot_cs", slot_cs, 4'b0000);
    chk("rst_cpu_rdy", cpu_rdy, 1'b1);
    chk("rst_cpu_irq", cpu_irq, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("settled_irq", cpu_irq, 1'b0);
    rd(16'h7001, r_di); chk("rst_enable", r_di, 8'h0F);
    rd(16'h7000, r_di); chk("rst_status", r_di, 8'h00);
    rd(16'h7002, r_di); chk("rst_vector", r_di, 8'h80);
    rd(16'h7003, r_di); chk("rst_raw", r_di, 8'h00);

    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i].addr, 1'b0, 8'h00, r_waits, r_cs, r_di, r_we, r_early, r_held, r_irq);
      chk($sformatf("tbl%0d_cs", i), r_cs, tbl[i].cs);
      chk($sformatf("tbl%0d_waits", i), r_waits, tbl[i].waits);
      chk($sformatf("tbl%0d_di", i), r_di, tbl[i].di);
      chk($sformatf("tbl%0d_held", i), r_held, 1'b1);
    end

    do_access(16'h5001, 1'b1, 8'hA5, r_waits, r_cs, r_di, r_we, r_early, r_held, r_irq);
    chk("wr_waits", r_waits, 3);
    chk("wr_early_we", r_early, 1'b0);
    chk("wr_final_we", r_we, 1'b1);
    chk("wr_addr_held", r_held, 1'b1);

    do_access(16'h4000, 1'b0, 8'h00, r_waits, r_cs, r_di, r_we, r_early, r_held, r_irq);
    chk("miss_di", r_di, 8'hFF);
    chk("miss_cs", r_cs, 4'b0000);
    rd(16'h7000, r_di); chk("miss_status", r_di, 8'h80);
    wr(16'h7000, 8'h7F);
    rd(16'h7000, r_di); chk("noclr_status", r_di, 8'h80);
    wr(16'h7000, 8'h80);
    rd(16'h7000, r_di); chk("clr_status", r_di, 8'h00);

    // Clear-write commit coincides with the address edge of a miss
    @(negedge clk); cpu_ad = 16'h7000; cpu_we = 1'b1; cpu_do = 8'h80;
    @(posedge clk); #1;
    cpu_ad = 16'h4000; cpu_we = 1'b0;
    @(posedge clk); #1;
    cpu_ad = IDLE;
    @(posedge clk); #1;
    rd(16'h7000, r_di); chk("race_status", r_di, 8'h80);
    wr(16'h7000, 8'h80);
    rd(16'h7000, r_di); chk("race_clr", r_di, 8'h00);

    @(negedge clk); slot_irq_n = 4'b0101;
    @(posedge clk); #1; chk("irq_lat1", cpu_irq, 1'b0);
    @(posedge clk); #1; chk("irq_lat2", cpu_irq, 1'b0);
    @(posedge clk); #1; chk("irq_lat3", cpu_irq, 1'b1);
    rd(16'h7002, r_di); chk("irq_vector", r_di, 8'h01);
    rd(16'h7003, r_di); chk("irq_raw", r_di, 8'h0A);
    rd(16'h7000, r_di); chk("irq_status", r_di, 8'h0A);
    wr(16'h7001, 8'hFD);
    rd(16'h7002, r_di); chk("irq_vector_fd", r_di, 8'h03);
    rd(16'h7001, r_di); chk("irq_enable_fd", r_di, 8'h0D);
    wr(16'h7001, 8'h00);
    chk("irq_dis_stale", cpu_irq, 1'b1);
    @(posedge clk); #1; chk("irq_dis", cpu_irq, 1'b0);
    rd(16'h7002, r_di); chk("irq_vector_none", r_di, 8'h80);
    wr(16'h7001, 8'h0F);
    @(negedge clk); slot_irq_n = 4'hF;
    repeat (4) @(posedge clk);
    #1;

    @(negedge clk); b_ad = 16'hF123;
    @(posedge clk); #1;
    chk("ovl_f123_cs", b_cs, 4'b0001);
    chk("ovl_f123_di", b_di, 8'hB0);
    @(negedge clk); b_ad = 16'h1234;
    @(posedge clk); #1;
    chk("ovl_1234_cs", b_cs, 4'b0100);
    b_ad = IDLE;

    en_m = 8'h0F; err_m = 1'b0; irq_n_m = 4'hF;
    for (int n = 0; n < 300; n++) begin
      if (n % 25 == 0) begin
        @(negedge clk);
        irq_n_m = 4'($urandom);
        slot_irq_n = irq_n_m;
        repeat (4) @(posedge clk);
        #1;
      end
      cat = $urandom_range(0, 9);
      if (cat <= 5) begin
        a = 16'($urandom); w = 1'($urandom_range(0, 1));
        if (model_decode(a) == -2) w = 1'b0;
      end else if (cat <= 7) begin
        a = 16'h7000 | 16'($urandom_range(0, 3)); w = 1'b0;
      end else if (cat == 8) begin
        a = 16'h7001; w = 1'b1;
      end else begin
        a = 16'h7000; w = 1'b1;
      end
      d = 8'($urandom);
      slot_do = $urandom;
      k = model_decode(a);
      pend_m = ~irq_n_m & en_m[3:0];
      vec_m = 8'h80;
      for (int i = 3; i >= 0; i--) if (pend_m[i]) vec_m = 8'(i);
      exp_cs = (k >= 0) ? 4'(1 << k) : 4'b0000;
      exp_wait = (k >= 0) ? wait_a[k] : 0;
      if (k >= 0) exp_di = slot_do[8*k +: 8];
      else if (k == -1) exp_di = 8'hFF;
      else if (a[1:0] == 2'd0) exp_di = {err_m, 3'b000, pend_m};
      else if (a[1:0] == 2'd1) exp_di = en_m;
      else if (a[1:0] == 2'd2) exp_di = vec_m;
      else exp_di = {4'h0, ~irq_n_m};
      do_access(a, w, d, r_waits, r_cs, r_di, r_we, r_early, r_held, r_irq);
      chk($sformatf("rnd%0d_cs a=%h", n, a), r_cs, exp_cs);
      chk($sformatf("rnd%0d_waits a=%h", n, a), r_waits, exp_wait);
      chk($sformatf("rnd%0d_we a=%h", n, a), {r_early, r_we}, {1'b0, w});
      chk($sformatf("rnd%0d_irq", n), r_irq, |pend_m);
      if (!w) chk($sformatf("rnd%0d_di a=%h", n, a), r_di, exp_di);
      if (k == -1) err_m = 1'b1;
      if (w && k == -2 && a[1:0] == 2'd1) en_m = d & 8'h0F;
      if (w && k == -2 && a[1:0] == 2'd0 && d[7]) err_m = 1'b0;
    end

    // Reset in the middle of a 5-cycle write wait
    @(negedge clk); cpu_ad = 16'h0010; cpu_we = 1'b1; cpu_do = 8'h55;
    @(posedge clk); #1;
    cpu_ad = IDLE; cpu_we = 1'b0;
    chk("midrst_waiting", cpu_rdy, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", cpu_rdy, 1'b1);
    chk("midrst_we", bus_we, 1'b0);
    chk("midrst_cs", slot_cs, 4'b0000);
    chk("midrst_addr", bus_addr, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    r_early = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_we) r_early = 1'b1;
    end
    chk("midrst_no_write", r_early, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
